alu_rs: RTL and testbench

Reservation station feeding the integer ALU in the out-of-order core. Holds issued ALU/branch micro-ops, snoops both CDB ports until operands resolve, dispatches at most one ready entry per cycle onto the ALU's `vj/vk/imm/op/waiting` inputs, and pairs the ALU's one-cycle-later result with the RoB tag of the dispatched entry to drive the ALU CDB port.

---
 rtl/alu_rs.sv | 212 +++++++++++++++++++++
 tb/tb_alu_rs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs -- reservation station in front of the integer ALU.
//
// Holds issued ALU/branch micro-ops and snoops both CDB ports until their
// operands resolve. Each cycle it dispatches the lowest-index ready entry onto
// the ALU inputs. It then pairs the ALU result, which arrives one cycle later,
// with the RoB tag of that entry to drive the ALU CDB port.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global stall (low = every register holds)
//   RoB_clear               mispredict flush, same effect as reset
//   issue_*                 one op from the decoder (issue_valid qualifies)
//   rs_full                 every entry busy (combinational)
//   lsb_cdb_*               load/store buffer broadcast
//   alu_vj/vk/imm/op        registered operands for the ALU
//   alu_waiting             registered "ALU has work this cycle"
//   ALU_finish_rdy/_value   ALU result, one cycle after alu_waiting
//   alu_cdb_*               ALU CDB broadcast (result paired with res_tag)
//
// Handshake: issue is accepted on a clock edge where rdy_in && issue_valid &&
// !rs_full. The decoder must not present issue_valid while rs_full is high.
// If it does, the op is dropped. The ALU path has no back-pressure:
// alu_waiting high for one cycle always produces ALU_finish_rdy in the next
// cycle.
module alu_rs #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 RoB_clear,
   input  logic                 issue_valid,
   input  logic [5:0]           issue_op,
   input  logic [31:0]          issue_vj,
   input  logic [31:0]          issue_vk,
   input  logic [31:0]          issue_imm,
   input  logic                 issue_qj_valid,
   input  logic                 issue_qk_valid,
   input  logic [ROB_WIDTH-1:0] issue_qj,
   input  logic [ROB_WIDTH-1:0] issue_qk,
   input  logic [ROB_WIDTH-1:0] issue_dest,
   output logic                 rs_full,
   input  logic                 lsb_cdb_valid,
   input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
   input  logic [31:0]          lsb_cdb_value,
   output logic [31:0]          alu_vj,
   output logic [31:0]          alu_vk,
   output logic [31:0]          alu_imm,
   output logic [5:0]           alu_op,
   output logic                 alu_waiting,
   input  logic                 ALU_finish_rdy,
   input  logic [31:0]          ALU_value,
   output logic                 alu_cdb_valid,
   output logic [ROB_WIDTH-1:0] alu_cdb_tag,
   output logic [31:0]          alu_cdb_value
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]   busy;
   logic [RS_SIZE-1:0]   qj_valid;
   logic [RS_SIZE-1:0]   qk_valid;
   logic [RS_SIZE-1:0]   ready;
   logic [5:0]           op_q   [RS_SIZE];
   logic [31:0]          vj_q   [RS_SIZE];
   logic [31:0]          vk_q   [RS_SIZE];
   logic [31:0]          imm_q  [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0] dest_q [RS_SIZE];

   logic [ROB_WIDTH-1:0] exe_tag;
   logic [ROB_WIDTH-1:0] res_tag;

   logic                 free_found;
   logic [IDX_W-1:0]     free_idx;
   logic                 ready_found;
   logic [IDX_W-1:0]     ready_idx;

   logic                 iss_qj_valid;
   logic                 iss_qk_valid;
   logic [31:0]          iss_vj;
   logic [31:0]          iss_vk;

   assign rs_full       = &busy;
   // Ready comes only from registered state, so a wakeup captured at an edge
   // can dispatch no earlier than the following edge.
   assign ready         = busy & ~qj_valid & ~qk_valid;

   assign alu_cdb_valid = ALU_finish_rdy;
   assign alu_cdb_tag   = res_tag;
   assign alu_cdb_value = ALU_value;

   // Lowest-index free and ready entries. The downward scan leaves the lowest
   // match as the final value.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      ready_found = 1'b0;
      ready_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = i[IDX_W-1:0];
         end
         if (ready[i]) begin
            ready_found = 1'b1;
            ready_idx   = i[IDX_W-1:0];
         end
      end
   end

   // Issue bypass. A producer broadcasting in the issue cycle resolves the
   // operand directly. The ALU port wins, although both ports never carry
   // the same tag.
   always_comb begin
      iss_qj_valid = issue_qj_valid;
      iss_vj       = issue_vj;
      iss_qk_valid = issue_qk_valid;
      iss_vk       = issue_vk;
      if (issue_qj_valid) begin
         if (alu_cdb_valid && alu_cdb_tag == issue_qj) begin
            iss_qj_valid = 1'b0;
            iss_vj       = alu_cdb_value;
         end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qj) begin
            iss_qj_valid = 1'b0;
            iss_vj       = lsb_cdb_value;
         end
      end
      if (issue_qk_valid) begin
         if (alu_cdb_valid && alu_cdb_tag == issue_qk) begin
            iss_qk_valid = 1'b0;
            iss_vk       = alu_cdb_value;
         end else if (lsb_cdb_valid && lsb_cdb_tag == issue_qk) begin
            iss_qk_valid = 1'b0;
            iss_vk       = lsb_cdb_value;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || RoB_clear) begin
         busy        <= '0;
         qj_valid    <= '0;
         qk_valid    <= '0;
         alu_vj      <= '0;
         alu_vk      <= '0;
         alu_imm     <= '0;
         alu_op      <= '0;
         alu_waiting <= 1'b0;
         exe_tag     <= '0;
         res_tag     <= '0;
      end else if (rdy_in) begin
         res_tag <= exe_tag;

         // Wakeup on both CDB ports.
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && qj_valid[i]) begin
               if (alu_cdb_valid && alu_cdb_tag == qj_q[i]) begin
                  qj_valid[i] <= 1'b0;
                  vj_q[i]     <= alu_cdb_value;
               end else if (lsb_cdb_valid && lsb_cdb_tag == qj_q[i]) begin
                  qj_valid[i] <= 1'b0;
                  vj_q[i]     <= lsb_cdb_value;
               end
            end
            if (busy[i] && qk_valid[i]) begin
               if (alu_cdb_valid && alu_cdb_tag == qk_q[i]) begin
                  qk_valid[i] <= 1'b0;
                  vk_q[i]     <= alu_cdb_value;
               end else if (lsb_cdb_valid && lsb_cdb_tag == qk_q[i]) begin
                  qk_valid[i] <= 1'b0;
                  vk_q[i]     <= lsb_cdb_value;
               end
            end
         end

         // Dispatch. The issue below can only target a non-busy entry, so it
         // never collides with the entry being freed here.
         if (ready_found) begin
            alu_vj          <= vj_q[ready_idx];
            alu_vk          <= vk_q[ready_idx];
            alu_imm         <= imm_q[ready_idx];
            alu_op          <= op_q[ready_idx];
            alu_waiting     <= 1'b1;
            exe_tag         <= dest_q[ready_idx];
            busy[ready_idx] <= 1'b0;
         end else begin
            alu_vj      <= '0;
            alu_vk      <= '0;
            alu_imm     <= '0;
            alu_op      <= '0;
            alu_waiting <= 1'b0;
         end

         if (issue_valid && free_found) begin
            busy[free_idx]     <= 1'b1;
            op_q[free_idx]     <= issue_op;
            vj_q[free_idx]     <= iss_vj;
            vk_q[free_idx]     <= iss_vk;
            imm_q[free_idx]    <= issue_imm;
            qj_valid[free_idx] <= iss_qj_valid;
            qk_valid[free_idx] <= iss_qk_valid;
            qj_q[free_idx]     <= issue_qj;
            qk_q[free_idx]     <= issue_qk;
            dest_q[free_idx]   <= issue_dest;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with a small ALU model for add/addi/sub.
module tb_alu_rs;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        RoB_clear;
   logic        issue_valid;
   logic [5:0]  issue_op;
   logic [31:0] issue_vj, issue_vk, issue_imm;
   logic        issue_qj_valid, issue_qk_valid;
   logic [3:0]  issue_qj, issue_qk, issue_dest;
   logic        rs_full;
   logic        lsb_cdb_valid;
   logic [3:0]  lsb_cdb_tag;
   logic [31:0] lsb_cdb_value;
   logic [31:0] alu_vj, alu_vk, alu_imm;
   logic [5:0]  alu_op;
   logic        alu_waiting;
   logic        ALU_finish_rdy;
   logic [31:0] ALU_value;
   logic        alu_cdb_valid;
   logic [3:0]  alu_cdb_tag;
   logic [31:0] alu_cdb_value;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   alu_rs #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj),
      .issue_vk(issue_vk), .issue_imm(issue_imm),
      .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
      .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
      .rs_full(rs_full),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag),
      .lsb_cdb_value(lsb_cdb_value),
      .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_op(alu_op),
      .alu_waiting(alu_waiting),
      .ALU_finish_rdy(ALU_finish_rdy), .ALU_value(ALU_value),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag),
      .alu_cdb_value(alu_cdb_value)
   );

   // ALU model: class 2'b11 uses vk, otherwise imm; funct3 000 is add, or
   // sub when alt is set on a register-register op.
   function automatic logic [31:0] alu_f(input logic [5:0] op,
                                         input logic [31:0] a, vk, imm);
      logic [31:0] b;
      b = (op[1:0] == 2'b11) ? vk : imm;
      if (op[4:2] != 3'b000) return 32'h0;
      return (op[5] && op[1:0] == 2'b11) ? a - b : a + b;
   endfunction

   always @(posedge clk_in) begin
      if (rst_in || RoB_clear) begin
         ALU_finish_rdy <= 1'b0;
         ALU_value      <= 32'h0;
      end else if (rdy_in) begin
         ALU_finish_rdy <= alu_waiting;
         ALU_value      <= alu_waiting ? alu_f(alu_op, alu_vj, alu_vk, alu_imm) : 32'h0;
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] vj, vk, imm,
                        input logic qjv, input logic [3:0] qj,
                        input logic qkv, input logic [3:0] qk,
                        input logic [3:0] dest);
      issue_valid    = 1'b1;
      issue_op       = op;
      issue_vj       = vj;
      issue_vk       = vk;
      issue_imm      = imm;
      issue_qj_valid = qjv;
      issue_qj       = qj;
      issue_qk_valid = qkv;
      issue_qk       = qk;
      issue_dest     = dest;
      step();
      issue_valid    = 1'b0;
      issue_qj_valid = 1'b0;
      issue_qk_valid = 1'b0;
   endtask

   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_ADD  = 6'b000011;
   localparam logic [5:0] OP_SUB  = 6'b100011;

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; RoB_clear = 1'b0;
      issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0;
      issue_imm = '0; issue_qj_valid = 1'b0; issue_qk_valid = 1'b0;
      issue_qj = '0; issue_qk = '0; issue_dest = '0;
      lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
      step(); step();
      rst_in = 1'b0;

      // Reset state
      chk("rst_waiting", alu_waiting, 0);
      chk("rst_op", alu_op, 0);
      chk("rst_vj", alu_vj, 0);
      chk("rst_cdb_valid", alu_cdb_valid, 0);
      chk("rst_cdb_tag", alu_cdb_tag, 0);
      chk("rst_full", rs_full, 0);

      // addi 5+7 -> dest 3
      issue(OP_ADDI, 5, 0, 7, 0, 0, 0, 0, 3);
      chk("addi_no_early", alu_waiting, 0);
      step();
      chk("addi_waiting", alu_waiting, 1);
      chk("addi_vj", alu_vj, 5);
      chk("addi_imm", alu_imm, 7);
      chk("addi_op", alu_op, OP_ADDI);
      step();
      chk("addi_cdb_valid", alu_cdb_valid, 1);
      chk("addi_cdb_tag", alu_cdb_tag, 3);
      chk("addi_cdb_value", alu_cdb_value, 12);
      step();
      chk("addi_cdb_off", alu_cdb_valid, 0);

      // sub with qj pending on tag 5 (resolved from LSB as 10), vk 4
      issue(OP_SUB, 0, 4, 0, 1, 5, 0, 0, 2);
      step();
      chk("sub_wait1", alu_waiting, 0);
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd5; lsb_cdb_value = 32'd10;
      step();
      lsb_cdb_valid = 1'b0;
      chk("sub_no_same_edge", alu_waiting, 0);
      step();
      chk("sub_waiting", alu_waiting, 1);
      chk("sub_vj", alu_vj, 10);
      chk("sub_vk", alu_vk, 4);
      step();
      chk("sub_cdb_valid", alu_cdb_valid, 1);
      chk("sub_cdb_tag", alu_cdb_tag, 2);
      chk("sub_cdb_value", alu_cdb_value, 6);
      step();

      // Fill all 8 entries pending on tag 9; the ninth issue is dropped
      for (int i = 0; i < 8; i++) begin
         chk("fill_not_full", rs_full, 0);
         issue(OP_ADD, 0, i, 0, 1, 9, 0, 0, i[3:0]);
      end
      chk("fill_full", rs_full, 1);
      issue(OP_ADD, 0, 100, 0, 0, 0, 0, 0, 15);
      chk("ninth_full", rs_full, 1);
      chk("ninth_no_dispatch", alu_waiting, 0);
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd9; lsb_cdb_value = 32'd1000;
      step();
      lsb_cdb_valid = 1'b0;
      chk("wake_no_dispatch", alu_waiting, 0);
      chk("wake_still_full", rs_full, 1);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("drain_waiting", alu_waiting, 1);
         chk("drain_order_vk", alu_vk, k);
         chk("drain_vj", alu_vj, 1000);
         if (k == 0) chk("drain_full_drop", rs_full, 0);
         if (k >= 1) begin
            chk("drain_cdb_valid", alu_cdb_valid, 1);
            chk("drain_cdb_tag", alu_cdb_tag, k - 1);
            chk("drain_cdb_value", alu_cdb_value, 1000 + k - 1);
         end
      end
      step();
      chk("drain_ninth_dropped", alu_waiting, 0);
      chk("drain_last_tag", alu_cdb_tag, 7);
      chk("drain_last_value", alu_cdb_value, 1007);
      step();
      chk("drain_cdb_off", alu_cdb_valid, 0);

      // Issue bypass from LSB in the issue cycle
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd4; lsb_cdb_value = 32'h8000_0000;
      issue(OP_ADD, 0, 1, 0, 1, 4, 0, 0, 6);
      lsb_cdb_valid = 1'b0;
      step();
      chk("byp_waiting", alu_waiting, 1);
      chk("byp_vj", alu_vj, 32'h8000_0000);
      step();
      chk("byp_cdb_tag", alu_cdb_tag, 6);
      chk("byp_cdb_value", alu_cdb_value, 32'h8000_0001);
      step();

      // Dependent chain: 20+22 -> tag 1, then tag1 + 8 -> tag 7
      issue(OP_ADD, 20, 22, 0, 0, 0, 0, 0, 1);
      issue(OP_ADD, 0, 8, 0, 1, 1, 0, 0, 7);
      chk("chain_first_waiting", alu_waiting, 1);
      chk("chain_first_vj", alu_vj, 20);
      step();
      chk("chain_first_cdb_tag", alu_cdb_tag, 1);
      chk("chain_first_cdb_value", alu_cdb_value, 42);
      chk("chain_idle1", alu_waiting, 0);
      step();
      chk("chain_idle2", alu_waiting, 0);
      step();
      chk("chain_second_waiting", alu_waiting, 1);
      chk("chain_second_vj", alu_vj, 42);
      step();
      chk("chain_second_cdb_tag", alu_cdb_tag, 7);
      chk("chain_second_cdb_value", alu_cdb_value, 50);
      step();

      // Flush with three busy entries and one op in flight
      issue(OP_ADD, 0, 1, 0, 1, 12, 0, 0, 8);
      issue(OP_ADD, 0, 2, 0, 1, 12, 0, 0, 9);
      issue(OP_ADD, 0, 3, 0, 1, 12, 0, 0, 10);
      issue(OP_ADD, 1, 1, 0, 0, 0, 0, 0, 11);
      step();
      chk("flush_inflight", alu_waiting, 1);
      RoB_clear = 1'b1;
      step();
      RoB_clear = 1'b0;
      chk("flush_waiting", alu_waiting, 0);
      chk("flush_cdb_valid", alu_cdb_valid, 0);
      chk("flush_cdb_tag", alu_cdb_tag, 0);
      chk("flush_full", rs_full, 0);
      chk("flush_op", alu_op, 0);
      step();
      chk("flush_no_stale", alu_cdb_valid, 0);
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd12; lsb_cdb_value = 32'd5;
      step();
      lsb_cdb_valid = 1'b0;
      step();
      chk("flush_no_revive", alu_waiting, 0);
      // All eight entries must be free again
      for (int i = 0; i < 7; i++) issue(OP_ADD, 0, 0, 0, 1, 13, 0, 0, 0);
      chk("refill_7_not_full", rs_full, 0);
      issue(OP_ADD, 0, 0, 0, 1, 13, 0, 0, 0);
      chk("refill_8_full", rs_full, 1);
      RoB_clear = 1'b1;
      step();
      RoB_clear = 1'b0;
      chk("reflush_full", rs_full, 0);

      // Stall mid-dispatch
      issue(OP_ADD, 3, 4, 0, 0, 0, 0, 0, 13);
      issue(OP_SUB, 10, 5, 0, 0, 0, 0, 0, 14);
      chk("stall_pre_waiting", alu_waiting, 1);
      rdy_in = 1'b0;
      for (int s = 0; s < 4; s++) begin
         step();
         chk("stall_waiting", alu_waiting, 1);
         chk("stall_vj", alu_vj, 3);
         chk("stall_cdb_valid", alu_cdb_valid, 0);
      end
      rdy_in = 1'b1;
      step();
      chk("resume_cdb_valid", alu_cdb_valid, 1);
      chk("resume_cdb_tag", alu_cdb_tag, 13);
      chk("resume_cdb_value", alu_cdb_value, 7);
      chk("resume_next_vj", alu_vj, 10);
      step();
      chk("resume2_cdb_tag", alu_cdb_tag, 14);
      chk("resume2_cdb_value", alu_cdb_value, 5);
      step();
      chk("resume_idle", alu_cdb_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
